// File: rtl/mcpu_ifetch_if.sv
// Bus bundle between the MCPU instruction fetch sequencer, the instruction ROM,
// the decoder, the redirect source and the debug/monitor read requester.
interface mcpu_ifetch_if #(
    parameter int AW = 14
);
    logic [AW-1:0] irom_addr0;
    logic [7:0]    irom_out0;
    logic [AW-1:0] irom_addr1;
    logic [7:0]    irom_out1;
    logic          ins_valid;
    logic [7:0]    ins_data;
    logic [AW-1:0] ins_addr;
    logic          ins_ready;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic          halt;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_ack;
    logic [7:0]    dbg_data;

    // The fetch sequencer side.
    modport slave (
        output irom_addr0, irom_addr1, ins_valid, ins_data, ins_addr, dbg_ack, dbg_data,
        input  irom_out0, irom_out1, ins_ready, redirect, redirect_addr, halt, dbg_req, dbg_addr
    );

    // The environment side: ROM, decoder, redirect source and debug requester.
    modport master (
        input  irom_addr0, irom_addr1, ins_valid, ins_data, ins_addr, dbg_ack, dbg_data,
        output irom_out0, irom_out1, ins_ready, redirect, redirect_addr, halt, dbg_req, dbg_addr
    );
endinterface

// File: rtl/mcpu_ifetch.sv
// MCPU instruction fetch sequencer: fetches up to two ROM bytes per cycle into a
// small byte FIFO ahead of the decoder and shares ROM port 1 with a debug reader.
module mcpu_ifetch #(
    parameter int                        IROM_ADDR_BITS = 14,
    parameter int                        FIFO_DEPTH     = 4,
    parameter logic [IROM_ADDR_BITS-1:0] RESET_ADDR     = {IROM_ADDR_BITS{1'b0}}
) (
    input  logic          clk,
    input  logic          reset_n,
    mcpu_ifetch_if.slave  bus
);
    localparam int AW = IROM_ADDR_BITS;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] TWO_C   = {{(CW-2){1'b0}}, 2'b10};

    logic [AW-1:0] fptr_q;
    logic [AW-1:0] fptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] rd_q;
    logic [PW-1:0] rd_d;
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic          dbg_ack_q;
    logic [7:0]    dbg_data_q;

    logic [CW-1:0] free_s;
    logic [1:0]    push_s;
    logic          pop_s;
    logic [PW-1:0] wr0_s;
    logic [PW-1:0] wr1_s;

    // Push/pop decision; free space deliberately ignores a same-cycle pop so
    // ins_ready never reaches the fetch path.
    always_comb begin
        free_s = DEPTH_C - count_q;
        pop_s  = (count_q != ZERO_C) && bus.ins_ready;
        if (bus.redirect || bus.halt) begin
            push_s = 2'd0;
        end else if ((free_s >= TWO_C) && !bus.dbg_req) begin
            push_s = 2'd2;
        end else if (free_s >= ONE_C) begin
            push_s = 2'd1;
        end else begin
            push_s = 2'd0;
        end
        wr0_s = rd_q + count_q[PW-1:0];
        wr1_s = wr0_s + {{(PW-1){1'b0}}, 1'b1};
    end

    // Next-state for fetch pointer, occupancy and read pointer; redirect flushes.
    always_comb begin
        if (bus.redirect) begin
            fptr_d  = bus.redirect_addr;
            count_d = ZERO_C;
            rd_d    = rd_q;
        end else begin
            fptr_d  = fptr_q + {{(AW-2){1'b0}}, push_s};
            count_d = count_q + {{(CW-2){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
            rd_d    = rd_q + {{(PW-1){1'b0}}, pop_s};
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fptr_q  <= RESET_ADDR;
            count_q <= ZERO_C;
            rd_q    <= {PW{1'b0}};
        end else begin
            fptr_q  <= fptr_d;
            count_q <= count_d;
            rd_q    <= rd_d;
        end
    end

    // FIFO byte storage; port 0 byte always lands first in stream order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 8'h00;
            end
        end else begin
            if (push_s != 2'd0) begin
                fifo_q[wr0_s] <= bus.irom_out0;
            end
            if (push_s == 2'd2) begin
                fifo_q[wr1_s] <= bus.irom_out1;
            end
        end
    end

    // Debug read return: port 1 belongs to the requester whenever it asks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbg_ack_q  <= 1'b0;
            dbg_data_q <= 8'h00;
        end else begin
            dbg_ack_q <= bus.dbg_req;
            if (bus.dbg_req) begin
                dbg_data_q <= bus.irom_out1;
            end
        end
    end

    assign bus.irom_addr0 = fptr_q;
    assign bus.irom_addr1 = bus.dbg_req ? bus.dbg_addr : (fptr_q + {{(AW-1){1'b0}}, 1'b1});
    assign bus.ins_valid  = (count_q != ZERO_C);
    assign bus.ins_data   = fifo_q[rd_q];
    assign bus.ins_addr   = fptr_q - {{(AW-CW){1'b0}}, count_q};
    assign bus.dbg_ack    = dbg_ack_q;
    assign bus.dbg_data   = dbg_data_q;
endmodule
